preproc_frame_ctrl: RTL

Sequencing controller for the preprocessing stage datapath, clocked in the ADC clock domain.
- Selects one of several 14-bit sample sources and applies a signed DC offset with saturation.
- Paces output at one sample per CLOCKS_PER_SAMPLE clocks and frames the stream into packets with a last flag.
- Runs a fixed number of packets per start command, or runs continuously.
- Downstream interface is stream-style (valid/ready/last).

---
 rtl/preproc_ctrl_pkg.sv | 43 ++++
 rtl/preproc_tick_gen.sv | 40 ++++
 rtl/preproc_frame_ctrl.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/preproc_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// preproc_ctrl_pkg
// Shared definitions for the preprocessing frame controller:
//   - state_t      : controller FSM states (IDLE, RUN, DRAIN)
//   - DEFAULT_*    : default sample width and sample pacing
//   - sat_add()    : signed add of sample and offset, saturated to a given
//                    two's complement width
// ---------------------------------------------------------------------------
package preproc_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int DEFAULT_ADC_WIDTH         = 14;
    localparam int DEFAULT_CLOCKS_PER_SAMPLE = 3;

    // Operands arrive sign-extended to 32 bits; the sum is formed one bit
    // wider so it can never wrap, then clamped to the signed range of
    // 'width' bits. Callers keep the low 'width' bits of the result.
    function automatic logic signed [31:0] sat_add(
        input logic signed [31:0] sample,
        input logic signed [31:0] offset,
        input int unsigned        width
    );
        logic signed [32:0] sum;
        logic signed [32:0] hi;
        logic signed [32:0] lo;
        sum = 33'(sample) + 33'(offset);
        hi  = (33'sd1 <<< (width - 1)) - 33'sd1;
        lo  = -(33'sd1 <<< (width - 1));
        if (sum > hi) begin
            sat_add = 32'(hi);
        end else if (sum < lo) begin
            sat_add = 32'(lo);
        end else begin
            sat_add = 32'(sum);
        end
    endfunction

endpackage

// File: rtl/preproc_tick_gen.sv
// ---------------------------------------------------------------------------
// preproc_tick_gen
// Sample pacing counter. While 'en' is high the counter runs
// 0..CLOCKS_PER_SAMPLE-1 and wraps; 'tick' is high whenever the count is 0,
// so the first tick lands on the first enabled cycle. While 'en' is low the
// counter is held at 0 and no tick is produced.
// Ports:
//   clk  : clock
//   rst  : synchronous active-high reset
//   en   : counter enable (controller is in RUN)
//   tick : sample strobe
// ---------------------------------------------------------------------------
module preproc_tick_gen
    import preproc_ctrl_pkg::*;
#(
    parameter int CLOCKS_PER_SAMPLE = DEFAULT_CLOCKS_PER_SAMPLE
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam int CNT_W = (CLOCKS_PER_SAMPLE > 1) ? $clog2(CLOCKS_PER_SAMPLE) : 1;

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || !en) begin
            cnt <= '0;
        end else if (cnt == CNT_W'(CLOCKS_PER_SAMPLE - 1)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign tick = en && (cnt == '0);

endmodule

// File: rtl/preproc_frame_ctrl.sv
// ---------------------------------------------------------------------------
// preproc_frame_ctrl
// Sequencing controller for the preprocessing datapath (ADC clock domain).
// Selects one of NUM_SOURCES signed samples, adds a signed offset with
// saturation, paces output at one sample per CLOCKS_PER_SAMPLE clocks and
// frames the stream into packets of cfg_pkt_len beats (tlast on the final
// beat). A run sends cfg_pkt_num packets, or runs until cfg_stop when
// cfg_pkt_num is 0; a stop always completes the current packet.
//
// Optional build macro PREPROC_TEST_PATTERN_EN: source NUM_SOURCES-1 is
// replaced by an internal ramp (0 at start, +1 per loaded beat); the
// corresponding src_data slice is then ignored.
//
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   cfg_start       : start pulse (honoured in IDLE only)
//   cfg_stop        : graceful stop pulse (honoured in RUN only)
//   cfg_sel_source  : source index
//   cfg_offset      : signed offset added to each sample
//   cfg_pkt_len     : samples per packet (0 behaves as 1)
//   cfg_pkt_num     : packets per run (0 = continuous)
//   src_data        : packed sources, source i at [i*ADC_WIDTH +: ADC_WIDTH]
//   m_tdata/m_tvalid/m_tready/m_tlast : output stream
//   busy            : high outside IDLE
//   pkt_done_cnt    : packets accepted downstream in this run
//   overrun         : sticky, a tick found the previous beat still pending
// ---------------------------------------------------------------------------
module preproc_frame_ctrl
    import preproc_ctrl_pkg::*;
#(
    parameter int ADC_WIDTH         = DEFAULT_ADC_WIDTH,
    parameter int CLOCKS_PER_SAMPLE = DEFAULT_CLOCKS_PER_SAMPLE,
    parameter int NUM_SOURCES       = 4,
    parameter int PKT_LEN_WIDTH     = 16,
    localparam int SEL_W            = (NUM_SOURCES > 1) ? $clog2(NUM_SOURCES) : 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             cfg_start,
    input  logic                             cfg_stop,
    input  logic [SEL_W-1:0]                 cfg_sel_source,
    input  logic signed [ADC_WIDTH-1:0]      cfg_offset,
    input  logic [PKT_LEN_WIDTH-1:0]         cfg_pkt_len,
    input  logic [PKT_LEN_WIDTH-1:0]         cfg_pkt_num,
    input  logic [NUM_SOURCES*ADC_WIDTH-1:0] src_data,
    output logic signed [ADC_WIDTH-1:0]      m_tdata,
    output logic                             m_tvalid,
    input  logic                             m_tready,
    output logic                             m_tlast,
    output logic                             busy,
    output logic [PKT_LEN_WIDTH-1:0]         pkt_done_cnt,
    output logic                             overrun
);

    state_t                      state;
    logic [SEL_W-1:0]            lat_sel;
    logic signed [ADC_WIDTH-1:0] lat_offset;
    logic [PKT_LEN_WIDTH-1:0]    lat_pkt_len;
    logic [PKT_LEN_WIDTH-1:0]    lat_pkt_num;
    logic [PKT_LEN_WIDTH-1:0]    idx;
    logic [PKT_LEN_WIDTH-1:0]    pkt_load_cnt;
    logic                        stop_flag;
    logic signed [ADC_WIDTH-1:0] sel_sample;
`ifdef PREPROC_TEST_PATTERN_EN
    logic signed [ADC_WIDTH-1:0] ramp;
`endif

    logic tick;
    logic accept;
    logic drop;
    logic load;
    logic is_last;
    logic final_pkt;

    preproc_tick_gen #(
        .CLOCKS_PER_SAMPLE(CLOCKS_PER_SAMPLE)
    ) u_tick_gen (
        .clk (clk),
        .rst (rst),
        .en  (state == RUN),
        .tick(tick)
    );

    // A tick that finds an unaccepted beat drops its sample; otherwise it
    // loads a beat (the pending one, if any, is being accepted this cycle).
    assign accept    = m_tvalid && m_tready;
    assign drop      = tick && m_tvalid && !m_tready;
    assign load      = tick && !drop;
    assign is_last   = (idx == lat_pkt_len - PKT_LEN_WIDTH'(1));
    assign final_pkt = (lat_pkt_num != '0) &&
                       (pkt_load_cnt == lat_pkt_num - PKT_LEN_WIDTH'(1));

    always_comb begin
        sel_sample = '0;
        for (int i = 0; i < NUM_SOURCES; i++) begin
            if (lat_sel == SEL_W'(i)) begin
                sel_sample = src_data[i*ADC_WIDTH +: ADC_WIDTH];
            end
        end
`ifdef PREPROC_TEST_PATTERN_EN
        if (lat_sel == SEL_W'(NUM_SOURCES - 1)) begin
            sel_sample = ramp;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            busy         <= 1'b0;
            m_tdata      <= '0;
            m_tvalid     <= 1'b0;
            m_tlast      <= 1'b0;
            pkt_done_cnt <= '0;
            overrun      <= 1'b0;
            lat_sel      <= '0;
            lat_offset   <= '0;
            lat_pkt_len  <= '0;
            lat_pkt_num  <= '0;
            idx          <= '0;
            pkt_load_cnt <= '0;
            stop_flag    <= 1'b0;
`ifdef PREPROC_TEST_PATTERN_EN
            ramp         <= '0;
`endif
        end else begin
            if (accept && m_tlast) begin
                pkt_done_cnt <= pkt_done_cnt + PKT_LEN_WIDTH'(1);
            end

            if (load) begin
                m_tvalid <= 1'b1;
                m_tdata  <= ADC_WIDTH'(sat_add(32'(sel_sample), 32'(lat_offset), ADC_WIDTH));
                m_tlast  <= is_last;
                idx      <= is_last ? '0 : idx + PKT_LEN_WIDTH'(1);
                if (is_last) begin
                    pkt_load_cnt <= pkt_load_cnt + PKT_LEN_WIDTH'(1);
                end
`ifdef PREPROC_TEST_PATTERN_EN
                ramp <= ramp + ADC_WIDTH'(1);
`endif
            end else if (accept) begin
                m_tvalid <= 1'b0;
            end

            if (drop) begin
                overrun <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (cfg_start) begin
                        lat_sel      <= cfg_sel_source;
                        lat_offset   <= cfg_offset;
                        lat_pkt_len  <= (cfg_pkt_len == '0) ? PKT_LEN_WIDTH'(1) : cfg_pkt_len;
                        lat_pkt_num  <= cfg_pkt_num;
                        pkt_done_cnt <= '0;
                        idx          <= '0;
                        pkt_load_cnt <= '0;
                        overrun      <= 1'b0;
                        stop_flag    <= 1'b0;
`ifdef PREPROC_TEST_PATTERN_EN
                        ramp         <= '0;
`endif
                        state        <= RUN;
                        busy         <= 1'b1;
                    end
                end
                RUN: begin
                    if (cfg_stop) begin
                        stop_flag <= 1'b1;
                    end
                    // Runs only end on a loaded tlast beat, never mid-packet.
                    if (load && is_last && (final_pkt || stop_flag || cfg_stop)) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (accept) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
